// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - signal encodings, scheduler states and road directions for intersection_scheduler
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;

  typedef enum logic [2:0] {
    ST_ALLRED,
    ST_NS_GREEN,
    ST_NS_YELLOW,
    ST_EW_GREEN,
    ST_EW_YELLOW,
    ST_WALK
  } state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  function automatic state_e green_of(input dir_e d);
    return (d == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// rtl/intersection_scheduler_if.sv - demand inputs and signal outputs of the scheduler
// INTERSECTION_PREEMPT_EN adds the preempt_i / preempt_dir_i lines.
interface intersection_scheduler_if;
  logic       car_ns_i;
  logic       car_ew_i;
  logic       walk_i;
  logic [1:0] sig_ns_o;
  logic [1:0] sig_ew_o;
  logic       walk_o;
  logic       walk_pend_o;
`ifdef INTERSECTION_PREEMPT_EN
  logic       preempt_i;
  logic       preempt_dir_i;

  modport master (output car_ns_i, car_ew_i, walk_i, preempt_i, preempt_dir_i,
                  input  sig_ns_o, sig_ew_o, walk_o, walk_pend_o);
  modport slave  (input  car_ns_i, car_ew_i, walk_i, preempt_i, preempt_dir_i,
                  output sig_ns_o, sig_ew_o, walk_o, walk_pend_o);
`else
  modport master (output car_ns_i, car_ew_i, walk_i,
                  input  sig_ns_o, sig_ew_o, walk_o, walk_pend_o);
  modport slave  (input  car_ns_i, car_ew_i, walk_i,
                  output sig_ns_o, sig_ew_o, walk_o, walk_pend_o);
`endif
endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// rtl/intersection_scheduler_phase_timer.sv - phase counter: clear, increment, saturate, terminal compare
module phase_timer #(
  parameter int W   = 4,
  parameter int SAT = 7
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (cnt_q != W'(SAT))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  // >= lets a resting phase (counter saturated) keep re-evaluating its exit
  assign term_o = (cnt_q >= term_i);

endmodule

// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - right-of-way sequencer for NS/EW roads and pedestrian walk
// Optional INTERSECTION_PREEMPT_EN enables emergency preemption toward one road.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 8,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 4
) (
  input logic                     clk,
  input logic                     rst_i,
  intersection_scheduler_if.slave bus
);

  localparam int MAX_A   = (GREEN_MAX > GREEN_MIN) ? GREEN_MAX : GREEN_MIN;
  localparam int MAX_B   = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_C > WALK_TIME) ? MAX_C : WALK_TIME;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  state_e             state_q, state_d;
  dir_e               next_dir_q, next_dir_d, other_dir;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cnt, term_val;
  logic               term;
  logic               own_car, oth_car, compete, max_out, nd_car, od_car;

  always_comb begin
    term_val = CNT_W'(ALLRED_TIME - 1);
    case (state_q)
      ST_NS_GREEN, ST_EW_GREEN:   term_val = CNT_W'(GREEN_MIN - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: term_val = CNT_W'(YELLOW_TIME - 1);
      ST_WALK:                    term_val = CNT_W'(WALK_TIME - 1);
      default:                    term_val = CNT_W'(ALLRED_TIME - 1);
    endcase
  end

  phase_timer #(.W(CNT_W), .SAT(GREEN_MAX - 1)) u_timer (
    .clk    (clk),
    .rst_i  (rst_i),
    .clr_i  (state_d != state_q),
    .term_i (term_val),
    .cnt_o  (cnt),
    .term_o (term)
  );

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    pend_d     = pend_q;
    own_car    = (state_q == ST_EW_GREEN) ? bus.car_ew_i : bus.car_ns_i;
    oth_car    = (state_q == ST_EW_GREEN) ? bus.car_ns_i : bus.car_ew_i;
    compete    = oth_car | pend_q;
    max_out    = (cnt == CNT_W'(GREEN_MAX - 1));
    other_dir  = (next_dir_q == DIR_NS) ? DIR_EW : DIR_NS;
    nd_car     = (next_dir_q == DIR_NS) ? bus.car_ns_i : bus.car_ew_i;
    od_car     = (next_dir_q == DIR_NS) ? bus.car_ew_i : bus.car_ns_i;

    case (state_q)
      ST_ALLRED: begin
        if (term) begin
          if (pend_q)      state_d = ST_WALK;
          else if (nd_car) state_d = green_of(next_dir_q);
          else if (od_car) state_d = green_of(other_dir);
        end
      end
      ST_NS_GREEN, ST_EW_GREEN: begin
        // gap-out, pending walk or max-out ends green only once competition exists
        if (term && compete && (!own_car || pend_q || max_out))
          state_d = (state_q == ST_NS_GREEN) ? ST_NS_YELLOW : ST_EW_YELLOW;
      end
      ST_NS_YELLOW: begin
        if (term) begin
          state_d    = ST_ALLRED;
          next_dir_d = DIR_EW;
        end
      end
      ST_EW_YELLOW: begin
        if (term) begin
          state_d    = ST_ALLRED;
          next_dir_d = DIR_NS;
        end
      end
      ST_WALK: begin
        if (term) state_d = ST_ALLRED;
      end
      default: state_d = ST_ALLRED;
    endcase

`ifdef INTERSECTION_PREEMPT_EN
    if (bus.preempt_i) begin
      case (state_q)
        ST_ALLRED:   if (term) state_d = bus.preempt_dir_i ? ST_EW_GREEN : ST_NS_GREEN;
        ST_NS_GREEN: state_d = bus.preempt_dir_i ? ST_NS_YELLOW : ST_NS_GREEN;
        ST_EW_GREEN: state_d = bus.preempt_dir_i ? ST_EW_GREEN : ST_EW_YELLOW;
        ST_WALK:     state_d = ST_ALLRED;
        default:     ;
      endcase
    end
`endif

    if (state_q != ST_WALK && bus.walk_i)
      pend_d = 1'b1;
    if (state_d == ST_WALK && state_q != ST_WALK)
      pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_ALLRED;
      next_dir_q <= DIR_NS;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.sig_ns_o    = (state_q == ST_NS_GREEN)  ? GREEN :
                           (state_q == ST_NS_YELLOW) ? YELLOW : RED;
  assign bus.sig_ew_o    = (state_q == ST_EW_GREEN)  ? GREEN :
                           (state_q == ST_EW_YELLOW) ? YELLOW : RED;
  assign bus.walk_o      = (state_q == ST_WALK);
  assign bus.walk_pend_o = pend_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - scoreboard bench for intersection_scheduler
module tb_intersection_scheduler;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] G = 2'd1;
  localparam logic [1:0] Y = 2'd2;

  typedef struct {
    logic       cn, ce, wk, pe, pd;
    logic [1:0] ns, ew;
    logic       wo, wp;
  } step_t;

  logic  clk = 1'b0;
  logic  rst_i;
  int    n_checks = 0;
  int    n_fail = 0;
  step_t sb_q[$];

  intersection_scheduler_if bus();

  intersection_scheduler dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic push(input int n, input logic cn, input logic ce, input logic wk,
                      input logic [1:0] ns, input logic [1:0] ew, input logic wo, input logic wp,
                      input logic pe = 1'b0, input logic pd = 1'b0);
    step_t s;
    s.cn = cn; s.ce = ce; s.wk = wk; s.pe = pe; s.pd = pd;
    s.ns = ns; s.ew = ew; s.wo = wo; s.wp = wp;
    repeat (n) sb_q.push_back(s);
  endtask

  task automatic apply(input step_t s);
    bus.car_ns_i = s.cn;
    bus.car_ew_i = s.ce;
    bus.walk_i   = s.wk;
`ifdef INTERSECTION_PREEMPT_EN
    bus.preempt_i     = s.pe;
    bus.preempt_dir_i = s.pd;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.car_ns_i = 1'b0;
    bus.car_ew_i = 1'b0;
    bus.walk_i   = 1'b0;
`ifdef INTERSECTION_PREEMPT_EN
    bus.preempt_i     = 1'b0;
    bus.preempt_dir_i = 1'b0;
`endif
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected 0/0/0/0",
               bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o);
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_release: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected 0/0/0/0",
               bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ns_rest();
    step_t s;
    int k = 0;
    do_reset();
    push(50, 1, 0, 0, G, R, 0, 0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      apply(s);
      n_checks++;
      if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== {s.ns, s.ew, s.wo, s.wp}) begin
        n_fail++;
        $display("FAIL ns_rest step %0d: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected %0d/%0d/%0b/%0b",
                 k, bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o, s.ns, s.ew, s.wo, s.wp);
      end
      k++;
    end
  endtask

  task automatic test_max_out();
    step_t s;
    int k = 0;
    do_reset();
    push(1, 1, 0, 0, G, R, 0, 0);
    push(7, 1, 1, 0, G, R, 0, 0);
    push(2, 1, 1, 0, Y, R, 0, 0);
    push(1, 1, 1, 0, R, R, 0, 0);
    push(3, 1, 1, 0, R, G, 0, 0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      apply(s);
      n_checks++;
      if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== {s.ns, s.ew, s.wo, s.wp}) begin
        n_fail++;
        $display("FAIL max_out step %0d: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected %0d/%0d/%0b/%0b",
                 k, bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o, s.ns, s.ew, s.wo, s.wp);
      end
      k++;
    end
  endtask

  task automatic test_gap_out();
    step_t s;
    int k = 0;
    do_reset();
    push(1, 1, 0, 0, G, R, 0, 0);
    push(1, 1, 1, 0, G, R, 0, 0);
    push(2, 0, 1, 0, G, R, 0, 0);
    push(2, 0, 1, 0, Y, R, 0, 0);
    push(1, 0, 1, 0, R, R, 0, 0);
    push(3, 0, 1, 0, R, G, 0, 0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      apply(s);
      n_checks++;
      if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== {s.ns, s.ew, s.wo, s.wp}) begin
        n_fail++;
        $display("FAIL gap_out step %0d: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected %0d/%0d/%0b/%0b",
                 k, bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o, s.ns, s.ew, s.wo, s.wp);
      end
      k++;
    end
  endtask

  task automatic test_walk();
    step_t s;
    int k = 0;
    do_reset();
    push(1, 1, 0, 0, G, R, 0, 0);
    push(1, 1, 1, 1, G, R, 0, 1);
    push(2, 1, 1, 0, G, R, 0, 1);
    push(2, 1, 1, 0, Y, R, 0, 1);
    push(1, 1, 1, 0, R, R, 0, 1);
    push(4, 1, 1, 0, R, R, 1, 0);
    push(1, 1, 1, 0, R, R, 0, 0);
    push(3, 1, 1, 0, R, G, 0, 0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      apply(s);
      n_checks++;
      if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== {s.ns, s.ew, s.wo, s.wp}) begin
        n_fail++;
        $display("FAIL walk step %0d: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected %0d/%0d/%0b/%0b",
                 k, bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o, s.ns, s.ew, s.wo, s.wp);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_yellow();
    step_t s;
    int k = 0;
    do_reset();
    push(1, 0, 1, 0, R, G, 0, 0);
    push(3, 1, 0, 0, R, G, 0, 0);
    push(1, 1, 0, 0, R, Y, 0, 0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      apply(s);
      n_checks++;
      if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== {s.ns, s.ew, s.wo, s.wp}) begin
        n_fail++;
        $display("FAIL to_yellow step %0d: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected %0d/%0d/%0b/%0b",
                 k, bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o, s.ns, s.ew, s.wo, s.wp);
      end
      k++;
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o} !== {R, R, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: ns/ew/walk = %0d/%0d/%0b, expected 0/0/0",
               bus.sig_ns_o, bus.sig_ew_o, bus.walk_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    k = 0;
    push(3, 1, 1, 0, G, R, 0, 0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      apply(s);
      n_checks++;
      if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== {s.ns, s.ew, s.wo, s.wp}) begin
        n_fail++;
        $display("FAIL ns_first step %0d: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected %0d/%0d/%0b/%0b",
                 k, bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o, s.ns, s.ew, s.wo, s.wp);
      end
      k++;
    end
  endtask

`ifdef INTERSECTION_PREEMPT_EN
  task automatic test_preempt();
    step_t s;
    int k = 0;
    do_reset();
    push(1,  0, 1, 0, R, G, 0, 0, 0, 0);
    push(2,  0, 1, 0, R, Y, 0, 0, 1, 0);
    push(1,  0, 1, 0, R, R, 0, 0, 1, 0);
    push(10, 0, 1, 0, G, R, 0, 0, 1, 0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      apply(s);
      n_checks++;
      if ({bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o} !== {s.ns, s.ew, s.wo, s.wp}) begin
        n_fail++;
        $display("FAIL preempt step %0d: ns/ew/walk/pend = %0d/%0d/%0b/%0b, expected %0d/%0d/%0b/%0b",
                 k, bus.sig_ns_o, bus.sig_ew_o, bus.walk_o, bus.walk_pend_o, s.ns, s.ew, s.wo, s.wp);
      end
      k++;
    end
    bus.preempt_i = 1'b0;
  endtask
`endif

  initial begin
    rst_i        = 1'b1;
    bus.car_ns_i = 1'b0;
    bus.car_ew_i = 1'b0;
    bus.walk_i   = 1'b0;
`ifdef INTERSECTION_PREEMPT_EN
    bus.preempt_i     = 1'b0;
    bus.preempt_dir_i = 1'b0;
`endif
    test_reset();
    test_ns_rest();
    test_max_out();
    test_gap_out();
    test_walk();
    test_reset_mid_yellow();
`ifdef INTERSECTION_PREEMPT_EN
    test_preempt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
